// File: rtl/rr_grant_encoder_if.sv
// Request/grant bundle between requesters and the round-robin grant encoder.
// The master side drives requests and release; the slave side returns the grant.
interface rr_grant_encoder_if;
  logic [3:0] req;
  logic       done;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  modport master (output req, done, input gnt_idx, gnt_vld, timeout);
  modport slave  (input req, done, output gnt_idx, gnt_vld, timeout);
endinterface

// File: rtl/rr_grant_encoder.sv
// Four-requester round-robin arbiter producing a registered grant index and valid
// for a downstream 2x4 decoder, with a hold limit that revokes long grants.
module rr_grant_encoder #(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  rr_grant_encoder_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  state_t           state_q, state_n;
  logic [1:0]       ptr_q, ptr_n;
  logic [CNT_W-1:0] hold_q, hold_n;
  logic [1:0]       idx_q, idx_n;
  logic             to_q, to_n;
  logic             rel_norm, rel_hold;

  // First requester found scanning from the priority pointer upward, modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] cand;
    logic       found;
    idx   = p;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cand = p + 2'(k);
      if (!found && r[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  always_comb begin
    state_n  = state_q;
    ptr_n    = ptr_q;
    hold_n   = hold_q;
    idx_n    = idx_q;
    to_n     = 1'b0;
    rel_norm = bus.done || !bus.req[idx_q];
    rel_hold = (hold_q == HOLD_LAST);
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          idx_n   = rr_pick(bus.req, ptr_q);
          hold_n  = '0;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (rel_norm || rel_hold) begin
          state_n = IDLE;
          ptr_n   = idx_q + 2'd1;
          // A hold-limit release coinciding with a normal release is not a timeout.
          to_n    = rel_hold && !rel_norm;
        end else begin
          hold_n  = hold_q + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Registered stage: grant state and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      hold_q  <= '0;
      idx_q   <= 2'd0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      ptr_q   <= ptr_n;
      hold_q  <= hold_n;
      idx_q   <= idx_n;
      to_q    <= to_n;
    end
  end

  assign bus.gnt_idx = idx_q;
  assign bus.gnt_vld = (state_q == GRANT);
  assign bus.timeout = to_q;

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Bench for rr_grant_encoder: directed scenarios with literal expectations, then random
// traffic, all compared every cycle against a behavioural round-robin model.
module tb_rr_grant_encoder;

  localparam int HOLD_MAX = 4;
  localparam int CNT_W    = 3;

  logic clk;
  logic rst;
  rr_grant_encoder_if bus ();

  rr_grant_encoder #(.HOLD_MAX(HOLD_MAX), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  logic chk_en = 1'b0;

  typedef struct {
    logic       busy;
    logic [1:0] ptr;
    logic [1:0] idx;
    logic       to;
    int         age;
  } m_t;

  m_t m = '{busy: 1'b0, ptr: 2'd0, idx: 2'd0, to: 1'b0, age: 0};

  // age = number of cycles the current grant has already been visible
  function automatic m_t model_next(input m_t s, input logic r_rst,
                                    input logic [3:0] r, input logic d);
    m_t n;
    bit normal;
    bit limit;
    int c;
    n = s;
    n.to = 1'b0;
    if (r_rst) begin
      n.busy = 1'b0; n.ptr = 2'd0; n.idx = 2'd0; n.age = 0;
    end else if (!s.busy) begin
      if (r != 4'd0) begin
        for (int k = 3; k >= 0; k--) begin
          c = (int'(s.ptr) + k) % 4;
          if (r[c]) n.idx = 2'(c);
        end
        n.busy = 1'b1;
        n.age  = 1;
      end
    end else begin
      normal = d || !r[s.idx];
      limit  = (s.age == HOLD_MAX);
      if (normal || limit) begin
        n.busy = 1'b0;
        n.ptr  = 2'((int'(s.idx) + 1) % 4);
        n.to   = limit && !normal;
      end else begin
        n.age = s.age + 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m <= model_next(m, rst, bus.req, bus.done);
    if (rst) chk_en <= 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (bus.gnt_vld !== m.busy) begin
        miscompares++;
        $display("FAIL model gnt_vld t=%0t: got %b want %b", $time, bus.gnt_vld, m.busy);
      end
      if (bus.gnt_idx !== m.idx) begin
        miscompares++;
        $display("FAIL model gnt_idx t=%0t: got %0d want %0d", $time, bus.gnt_idx, m.idx);
      end
      if (bus.timeout !== m.to) begin
        miscompares++;
        $display("FAIL model timeout t=%0t: got %b want %b", $time, bus.timeout, m.to);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [1:0] vld_exp,
                     input logic [1:0] idx_exp, input logic to_exp);
    vectors++;
    if ({1'b0, bus.gnt_vld} !== vld_exp || bus.gnt_idx !== idx_exp || bus.timeout !== to_exp) begin
      miscompares++;
      $display("FAIL %s: got vld=%b idx=%0d to=%b want vld=%b idx=%0d to=%b",
               name, bus.gnt_vld, bus.gnt_idx, bus.timeout, vld_exp[0], idx_exp, to_exp);
    end
  endtask

  initial begin
    rst = 1'b1; bus.req = 4'b1111; bus.done = 1'b0;
    // Reset held with all requests pending
    cyc(2);
    lit("reset_hold", 2'd0, 2'd0, 1'b0);
    rst = 1'b0;
    cyc(1);
    lit("first_grant", 2'd1, 2'd0, 1'b0);
    bus.req = 4'b0000;
    cyc(1);
    lit("req_drop_release", 2'd0, 2'd0, 1'b0);
    cyc(1);

    // Single request, released by done
    bus.req = 4'b0100;
    cyc(1);
    lit("single_grant", 2'd1, 2'd2, 1'b0);
    cyc(2);
    lit("single_still", 2'd1, 2'd2, 1'b0);
    bus.done = 1'b1;
    cyc(1);
    lit("single_done", 2'd0, 2'd2, 1'b0);
    bus.done = 1'b0; bus.req = 4'b0000;
    cyc(1);

    // Rotation with done in each grant's first cycle
    rst = 1'b1;
    cyc(1);
    rst = 1'b0; bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      cyc(1);
      lit("rotate_grant", 2'd1, 2'(g % 4), 1'b0);
      bus.done = 1'b1;
      cyc(1);
      lit("rotate_bubble", 2'd0, 2'(g % 4), 1'b0);
      bus.done = 1'b0;
    end
    bus.req = 4'b0000;
    cyc(1);

    // Hold-limit timeout
    bus.req = 4'b0010;
    cyc(1);
    lit("hold_c1", 2'd1, 2'd1, 1'b0);
    cyc(3);
    lit("hold_c4", 2'd1, 2'd1, 1'b0);
    cyc(1);
    lit("timeout_pulse", 2'd0, 2'd1, 1'b1);
    cyc(1);
    lit("regrant_after_to", 2'd1, 2'd1, 1'b0);
    bus.req = 4'b0000;
    cyc(2);

    // Drop of granted request, pointer wrap, done on the hold-limit cycle
    rst = 1'b1;
    cyc(1);
    rst = 1'b0; bus.req = 4'b1000;
    cyc(1);
    lit("grant3", 2'd1, 2'd3, 1'b0);
    cyc(1);
    bus.req = 4'b0000;
    cyc(1);
    lit("drop3", 2'd0, 2'd3, 1'b0);
    bus.req = 4'b1001;
    cyc(1);
    lit("wrap_to0", 2'd1, 2'd0, 1'b0);
    cyc(3);
    bus.done = 1'b1;
    cyc(1);
    lit("tie_no_timeout", 2'd0, 2'd0, 1'b0);
    bus.done = 1'b0; bus.req = 4'b0000;
    cyc(1);

    // Reset in the middle of a grant
    bus.req = 4'b0100;
    cyc(1);
    lit("pre_rst_grant", 2'd1, 2'd2, 1'b0);
    rst = 1'b1;
    cyc(1);
    lit("rst_mid_grant", 2'd0, 2'd0, 1'b0);
    rst = 1'b0; bus.req = 4'b1100;
    cyc(1);
    lit("post_rst_grant", 2'd1, 2'd2, 1'b0);

    // Random traffic checked by the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom_range(0, 15));
      bus.done = ($urandom_range(0, 5) == 0);
      rst      = ($urandom_range(0, 149) == 0);
      cyc(1);
    end
    rst = 1'b0; bus.req = 4'b0000; bus.done = 1'b0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
